orsram_drain: RTL and testbench

Output write-back engine for the output SRAM. Once the SRAM controller has filled `orsram` with pooled results, this block reads a contiguous run of words from it and streams them toward DRAM over a valid/ready interface. It absorbs the one-cycle SRAM read latency with a 2-entry skid FIFO, so it sustains one word per cycle under continuous `dram_ready`. The top level muxes the `orsram` control pins to this block while `busy` is high.

---
 rtl/orsram_drain.sv | 186 ++++++++++++++++++
 tb/tb_orsram_drain.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/orsram_drain.sv
// Purpose: streams a contiguous run of orsram words toward DRAM over valid/ready.
// Latency: 3 cycles from an accepted start to the first dram_valid; 1 word/cycle sustained.
// Backpressure: dram_ready low holds dram_data; reads stop when the 2-entry skid FIFO would fill.
//
// Ports:
//   clk, rst          single clock, synchronous active-high reset
//   start, base_addr, num_words   job request (sampled only in IDLE)
//   CEN_or, WEN_or, A_or, Q_or    orsram read port (WEN_or held all-ones)
//   dram_data, dram_valid, dram_ready, dram_last   outbound word stream
//   busy, done        job status; done is a one-cycle pulse
//   stall_cnt         cycles with dram_valid & ~dram_ready
// Optional feature: define ORSRAM_DRAIN_PERF_EN to build the stall counter;
// otherwise stall_cnt is tied to zero.

// Small generic FIFO with occupancy output; head word is shown combinationally.
module orsram_drain_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 2,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [W-1:0]  push_dat,
  input  logic          pop,
  output logic [W-1:0]  head_dat,
  output logic [CW-1:0] cnt
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  function automatic logic [AW-1:0] ptr_next(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign head_dat = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      // Storage is cleared so the head word reads as zero out of reset.
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_dat;
        wr_ptr      <= ptr_next(wr_ptr);
      end
      if (pop) rd_ptr <= ptr_next(rd_ptr);
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end
endmodule

module orsram_drain #(
  parameter int DATA_W   = 256,
  parameter int ADDR_W   = 7,
  parameter int SRAM_NUM = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [ADDR_W-1:0]   base_addr,
  input  logic [ADDR_W:0]     num_words,
  output logic                CEN_or,
  output logic [SRAM_NUM-1:0] WEN_or,
  output logic [ADDR_W-1:0]   A_or,
  input  logic [DATA_W-1:0]   Q_or,
  output logic [DATA_W-1:0]   dram_data,
  output logic                dram_valid,
  input  logic                dram_ready,
  output logic                dram_last,
  output logic                busy,
  output logic                done,
  output logic [15:0]         stall_cnt
);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_READ  = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [ADDR_W:0] ONE_W = {{ADDR_W{1'b0}}, 1'b1};

  logic [1:0]        state;
  logic [ADDR_W:0]   rd_left;
  logic [ADDR_W:0]   wr_left;
  logic [ADDR_W-1:0] rd_addr;
  logic [ADDR_W-1:0] a_hold;
  logic              inflight;
  logic              issue;
  logic              pop;
  logic [1:0]        fifo_cnt;
  logic [DATA_W-1:0] fifo_head;

  assign dram_valid = (fifo_cnt != 2'd0);
  assign pop        = dram_valid & dram_ready;

  // A new read is allowed only if the word it returns next cycle still fits:
  // occupancy after this cycle (cnt + inflight - pop) must leave one free slot.
  assign issue = (state == S_READ) && (rd_left != '0) &&
                 (({1'b0, fifo_cnt} + {2'b00, inflight}) <= (3'd1 + {2'b00, pop}));

  assign CEN_or    = ~issue;
  assign WEN_or    = '1;
  assign A_or      = issue ? rd_addr : a_hold;
  assign dram_data = fifo_head;
  assign dram_last = dram_valid & (wr_left == ONE_W);
  assign busy      = (state == S_READ) || (state == S_FLUSH);
  assign done      = (state == S_DONE);

  orsram_drain_fifo #(
    .W     (DATA_W),
    .DEPTH (2),
    .CW    (2)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (inflight),
    .push_dat (Q_or),
    .pop      (pop),
    .head_dat (fifo_head),
    .cnt      (fifo_cnt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      rd_left  <= '0;
      wr_left  <= '0;
      rd_addr  <= '0;
      a_hold   <= '0;
      inflight <= 1'b0;
    end else begin
      // Read data returns one cycle after issue; a reset drops it with inflight.
      inflight <= issue;
      if (issue) begin
        a_hold  <= rd_addr;
        rd_addr <= rd_addr + 1'b1;
        rd_left <= rd_left - 1'b1;
      end
      if (pop) wr_left <= wr_left - 1'b1;

      case (state)
        S_IDLE: begin
          if (start) begin
            rd_left <= num_words;
            wr_left <= num_words;
            rd_addr <= base_addr;
            state   <= (num_words == '0) ? S_DONE : S_READ;
          end
        end
        S_READ:  if (issue && (rd_left == ONE_W)) state <= S_FLUSH;
        S_FLUSH: if (pop && (wr_left == ONE_W)) state <= S_DONE;
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef ORSRAM_DRAIN_PERF_EN
  logic [15:0] stall_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= '0;
    end else if ((state == S_IDLE) && start) begin
      stall_q <= '0;
    end else if (dram_valid && !dram_ready && (stall_q != 16'hFFFF)) begin
      stall_q <= stall_q + 16'd1;
    end
  end

  assign stall_cnt = stall_q;
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_orsram_drain.sv
module tb_orsram_drain;
  localparam int DATA_W   = 256;
  localparam int ADDR_W   = 7;
  localparam int SRAM_NUM = 32;

  logic                clk = 1'b0;
  logic                rst;
  logic                start;
  logic [ADDR_W-1:0]   base_addr;
  logic [ADDR_W:0]     num_words;
  logic                CEN_or;
  logic [SRAM_NUM-1:0] WEN_or;
  logic [ADDR_W-1:0]   A_or;
  logic [DATA_W-1:0]   Q_or;
  logic [DATA_W-1:0]   dram_data;
  logic                dram_valid;
  logic                dram_ready;
  logic                dram_last;
  logic                busy;
  logic                done;
  logic [15:0]         stall_cnt;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  orsram_drain #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .SRAM_NUM (SRAM_NUM)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .base_addr  (base_addr),
    .num_words  (num_words),
    .CEN_or     (CEN_or),
    .WEN_or     (WEN_or),
    .A_or       (A_or),
    .Q_or       (Q_or),
    .dram_data  (dram_data),
    .dram_valid (dram_valid),
    .dram_ready (dram_ready),
    .dram_last  (dram_last),
    .busy       (busy),
    .done       (done),
    .stall_cnt  (stall_cnt)
  );

  // SRAM model: one-cycle read latency.
  logic [DATA_W-1:0] mem [128];
  always @(posedge clk) if (!CEN_or) Q_or <= mem[A_or];

  // FIFO occupancy must never exceed its two entries.
  bit ovf_seen = 1'b0;
  always @(negedge clk) begin
    if (!rst) assert (dut.fifo_cnt <= 2'd2) else ovf_seen = 1'b1;
  end

  // Observations collected by run_job.
  int                rd_q[$];
  int                rd_cyc[$];
  logic [DATA_W-1:0] dat_q[$];
  bit                last_q[$];
  int                xfer_cyc[$];
  int                done_cyc[$];
  bit                busy_q[$];
  int                stall_obs, stable_err, last_err, wen_err;
  bit                snap_taken;
  logic [4:0]        snap_ctl;
  logic [ADDR_W-1:0] snap_a;
  logic [DATA_W-1:0] snap_data;
  logic [15:0]       snap_stall;

  function automatic logic [DATA_W-1:0] exp_word(input int base, input int i);
    return mem[(base + i) % 128];
  endfunction

  function automatic logic pick_ready(input int mode, input int cyc);
    if (mode == 0) return 1'b1;
    if (mode == 1) return (cyc % 2) == 0;
    return 1'($urandom_range(0, 1));
  endfunction

  // Drives one job (start in cycle 0) and records what the DUT does per cycle.
  task automatic run_job(input int base, input int n, input int mode, input int budget,
                         input int restart_at, input int rst_at);
    bit                prev_stall;
    logic [DATA_W-1:0] prev_dat;
    int                tail;
    rd_q.delete(); rd_cyc.delete(); dat_q.delete(); last_q.delete();
    xfer_cyc.delete(); done_cyc.delete(); busy_q.delete();
    stall_obs = 0; stable_err = 0; last_err = 0; wen_err = 0; snap_taken = 1'b0;
    prev_stall = 1'b0; prev_dat = '0; tail = -1;
    for (int c = 0; c <= budget; c++) begin
      @(posedge clk); #1;
      start = (c == 0) || (c == restart_at);
      if (c == 0) begin
        base_addr = ADDR_W'(base);
        num_words = (ADDR_W+1)'(n);
      end else if (c == restart_at) begin
        base_addr = ADDR_W'(base + 50);
        num_words = 8'd3;
      end
      rst        = (c == rst_at);
      dram_ready = pick_ready(mode, c);
      @(negedge clk);
      if (rst_at >= 0 && c == rst_at + 1) begin
        snap_taken = 1'b1;
        snap_ctl   = {CEN_or, dram_valid, dram_last, busy, done};
        snap_a     = A_or;
        snap_data  = dram_data;
        snap_stall = stall_cnt;
      end
      if (!CEN_or) begin rd_q.push_back(int'(A_or)); rd_cyc.push_back(c); end
      if (dram_valid && dram_ready) begin
        dat_q.push_back(dram_data); last_q.push_back(dram_last); xfer_cyc.push_back(c);
      end
      if (dram_valid && !dram_ready) stall_obs++;
      if (prev_stall && (!dram_valid || dram_data !== prev_dat)) stable_err++;
      prev_stall = dram_valid && !dram_ready;
      prev_dat   = dram_data;
      if (dram_last && !dram_valid) last_err++;
      if (WEN_or !== '1) wen_err++;
      if (done) done_cyc.push_back(c);
      busy_q.push_back(busy);
      if (done && tail < 0) tail = 2;
      if (tail == 0) break;
      if (tail > 0) tail--;
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; dram_ready = 1'b0; base_addr = '0; num_words = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    tests++;
    if ({CEN_or, dram_valid, dram_last, busy, done} !== 5'b10000)
      begin fails++; $display("FAIL reset_ctl got=%b want=10000", {CEN_or, dram_valid, dram_last, busy, done}); end
    tests++;
    if (A_or !== '0) begin fails++; $display("FAIL reset_addr got=%0d want=0", A_or); end
    tests++;
    if (dram_data !== '0) begin fails++; $display("FAIL reset_data got=%h want=0", dram_data); end
    tests++;
    if (WEN_or !== '1) begin fails++; $display("FAIL reset_wen got=%h want=all-ones", WEN_or); end
    tests++;
    if (stall_cnt !== 16'd0) begin fails++; $display("FAIL reset_stall got=%0d want=0", stall_cnt); end
    @(posedge clk); #1 rst = 1'b0;
  endtask

  task automatic test_basic();
    int bad;
    run_job(0, 4, 0, 30, -1, -1);
    bad = (rd_q.size() != 4) ? 1 : 0;
    foreach (rd_q[i]) if (rd_q[i] != i || rd_cyc[i] != i + 1) bad++;
    tests++;
    if (bad != 0) begin fails++; $display("FAIL basic_reads got=%0d reads with %0d errors want=4 at cycles 1-4", rd_q.size(), bad); end
    bad = (dat_q.size() != 4) ? 1 : 0;
    foreach (dat_q[i])
      if (dat_q[i] !== exp_word(0, i) || xfer_cyc[i] != i + 3 || last_q[i] !== (i == 3)) bad++;
    tests++;
    if (bad != 0) begin fails++; $display("FAIL basic_xfers got=%0d words with %0d errors want=4 at cycles 3-6", dat_q.size(), bad); end
    tests++;
    if (done_cyc.size() != 1 || done_cyc[0] != 7)
      begin fails++; $display("FAIL basic_done got=%0d pulses first=%0d want=1 at cycle 7", done_cyc.size(), (done_cyc.size() > 0) ? done_cyc[0] : -1); end
    bad = 0;
    foreach (busy_q[i]) if (busy_q[i] !== (i >= 1 && i <= 6)) bad++;
    tests++;
    if (bad != 0) begin fails++; $display("FAIL basic_busy got=%0d bad cycles want=0", bad); end
    tests++;
    if (wen_err != 0 || last_err != 0) begin fails++; $display("FAIL basic_wen_last got=%0d/%0d want=0/0", wen_err, last_err); end
  endtask

  task automatic test_backpressure();
    int bad, exp_stall;
    for (int k = 0; k < 4; k++) begin
      int base = (k == 0) ? 0 : int'($urandom_range(0, 127));
      int n    = (k == 0) ? 4 : int'($urandom_range(1, 20));
      run_job(base, n, (k == 0) ? 1 : 2, 200, -1, -1);
      bad = (dat_q.size() != n) ? 1 : 0;
      foreach (dat_q[i]) if (dat_q[i] !== exp_word(base, i) || last_q[i] !== (i == n - 1)) bad++;
      tests++;
      if (bad != 0) begin fails++; $display("FAIL bp_words job=%0d got=%0d words %0d errors want=%0d", k, dat_q.size(), bad, n); end
      tests++;
      if (stable_err != 0) begin fails++; $display("FAIL bp_stable job=%0d got=%0d changes want=0", k, stable_err); end
      tests++;
      if (done_cyc.size() != 1 || xfer_cyc.size() == 0 || done_cyc[0] != xfer_cyc[$] + 1)
        begin fails++; $display("FAIL bp_done job=%0d got=%0d pulses want=1 after last word", k, done_cyc.size()); end
`ifdef ORSRAM_DRAIN_PERF_EN
      exp_stall = stall_obs;
`else
      exp_stall = 0;
`endif
      tests++;
      if (stall_cnt !== 16'(exp_stall)) begin fails++; $display("FAIL bp_stall job=%0d got=%0d want=%0d", k, stall_cnt, exp_stall); end
    end
  endtask

  task automatic test_wrap();
    int bad;
    run_job(126, 4, 0, 30, -1, -1);
    bad = (rd_q.size() != 4) ? 1 : 0;
    foreach (rd_q[i]) if (rd_q[i] != (126 + i) % 128) bad++;
    tests++;
    if (bad != 0) begin fails++; $display("FAIL wrap_addr got=%0d reads %0d errors want=126,127,0,1", rd_q.size(), bad); end
    bad = (dat_q.size() != 4) ? 1 : 0;
    foreach (dat_q[i]) if (dat_q[i] !== exp_word(126, i)) bad++;
    tests++;
    if (bad != 0) begin fails++; $display("FAIL wrap_data got=%0d words %0d errors want=4", dat_q.size(), bad); end
  endtask

  task automatic test_zero();
    int bad = 0;
    run_job(5, 0, 0, 20, -1, -1);
    tests++;
    if (done_cyc.size() != 1 || done_cyc[0] != 1)
      begin fails++; $display("FAIL zero_done got=%0d pulses want=1 at cycle 1", done_cyc.size()); end
    foreach (busy_q[i]) if (busy_q[i]) bad++;
    tests++;
    if (rd_q.size() != 0 || dat_q.size() != 0 || bad != 0 || stall_obs != 0)
      begin fails++; $display("FAIL zero_quiet got reads=%0d words=%0d busy=%0d want=0/0/0", rd_q.size(), dat_q.size(), bad); end
  endtask

  task automatic test_restart_ignored();
    int bad;
    run_job(10, 8, 0, 40, 2, -1);
    bad = (dat_q.size() != 8 || rd_q.size() != 8) ? 1 : 0;
    foreach (dat_q[i]) if (dat_q[i] !== exp_word(10, i) || last_q[i] !== (i == 7)) bad++;
    tests++;
    if (bad != 0) begin fails++; $display("FAIL restart_words got=%0d words %0d errors want=8", dat_q.size(), bad); end
    tests++;
    if (done_cyc.size() != 1 || done_cyc[0] != 11)
      begin fails++; $display("FAIL restart_done got=%0d pulses want=1 at cycle 11", done_cyc.size()); end
  endtask

  task automatic test_reset_mid();
    int bad;
    run_job(20, 8, 0, 12, -1, 4);
    tests++;
    if (!snap_taken || snap_ctl !== 5'b10000 || snap_a !== '0 || snap_data !== '0 || snap_stall !== 16'd0)
      begin fails++; $display("FAIL midrst_values got ctl=%b a=%0d stall=%0d want ctl=10000 a=0 stall=0", snap_ctl, snap_a, snap_stall); end
    tests++;
    if (done_cyc.size() != 0) begin fails++; $display("FAIL midrst_nodone got=%0d pulses want=0", done_cyc.size()); end
    run_job(40, 5, 0, 30, -1, -1);
    bad = (dat_q.size() != 5) ? 1 : 0;
    foreach (dat_q[i]) if (dat_q[i] !== exp_word(40, i)) bad++;
    tests++;
    if (bad != 0 || done_cyc.size() != 1 || done_cyc[0] != 8)
      begin fails++; $display("FAIL midrst_rerun got=%0d words %0d errors, %0d pulses want=5 words done at 8", dat_q.size(), bad, done_cyc.size()); end
  endtask

  task automatic test_random();
    for (int k = 0; k < 8; k++) begin
      int base = int'($urandom_range(0, 127));
      int n    = (k == 0) ? 128 : int'($urandom_range(1, 128));
      int mode = int'($urandom_range(0, 2));
      int bad, bbad;
      run_job(base, n, mode, 4 * n + 20, -1, -1);
      bad = (dat_q.size() != n || rd_q.size() != n) ? 1 : 0;
      foreach (rd_q[i]) if (rd_q[i] != (base + i) % 128) bad++;
      foreach (dat_q[i]) if (dat_q[i] !== exp_word(base, i) || last_q[i] !== (i == n - 1)) bad++;
      tests++;
      if (bad != 0 || stable_err != 0)
        begin fails++; $display("FAIL rand_stream job=%0d n=%0d got=%0d words %0d errors %0d unstable", k, n, dat_q.size(), bad, stable_err); end
      bbad = 0;
      if (done_cyc.size() == 1)
        foreach (busy_q[i]) if (busy_q[i] !== (i >= 1 && i < done_cyc[0])) bbad++;
      tests++;
      if (done_cyc.size() != 1 || bbad != 0 || done_cyc[0] != xfer_cyc[$] + 1 ||
          (mode == 0 && done_cyc[0] != n + 3))
        begin fails++; $display("FAIL rand_done job=%0d got=%0d pulses %0d busy errors want=1/0", k, done_cyc.size(), bbad); end
    end
  endtask

  initial begin
    for (int i = 0; i < 128; i++)
      for (int j = 0; j < DATA_W / 32; j++) mem[i][j*32 +: 32] = $urandom();
    test_reset();
    test_basic();
    test_backpressure();
    test_wrap();
    test_zero();
    test_restart_ignored();
    test_reset_mid();
    test_random();
    tests++;
    if (ovf_seen !== 1'b0) begin fails++; $display("FAIL fifo_overflow got=occupancy>2 want<=2"); end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
